// File: rtl/kt_pkg.sv
// Shared types, default parameters and width helper for the kitchen timer control stage.
package kt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } kt_state_e;

  // One accepted press event per button, all in the same cycle
  typedef struct packed {
    logic start;
    logic min;
    logic sec;
    logic clr;
  } kt_press_t;

  localparam int unsigned CLK_HZ_DEF          = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int unsigned ALARM_SECS_DEF      = 10;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kt_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, single-cycle press pulse
// on an accepted high-to-low transition of an active-low button.
module kt_debounce
  import kt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned DB_W   = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned DB_MAX = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Any cycle where the synchronized level agrees with the accepted level restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DB_W'(DB_MAX)) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ktimer_ctrl.sv
// Kitchen timer control: button debounce, IDLE/RUN/PAUSE/ALARM FSM, one-second prescaler,
// alarm timeout. KTIMER_CHIRP_EN selects a 4 Hz chirping buzzer instead of a steady one.
module ktimer_ctrl
  import kt_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned ALARM_SECS      = ALARM_SECS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_n,
  input  logic btn_min_n,
  input  logic btn_sec_n,
  input  logic btn_clr_n,
  input  logic zero,
  output logic sec_bin,
  output logic min_bin,
  output logic clr,
  output logic running,
  output logic buzzer
);

  localparam int unsigned PRE_W    = cnt_w(CLK_HZ);
  localparam int unsigned PRE_MAX  = (CLK_HZ > 0) ? CLK_HZ - 1 : 0;
  localparam int unsigned ASEC_W   = cnt_w(ALARM_SECS);
  localparam int unsigned ASEC_MAX = (ALARM_SECS > 0) ? ALARM_SECS - 1 : 0;

  kt_press_t        press;
  logic             any_press;
  kt_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             pre_tc;
  logic [ASEC_W-1:0] asec_q, asec_d;
  logic             sec_bin_q, sec_bin_d;
  logic             min_bin_q, min_bin_d;
  logic             clr_q, clr_d;
  logic             running_q, running_d;
  logic             buzzer_q, buzzer_d;

  kt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .reset(reset), .btn_n_i(btn_start_n), .press_o(press.start)
  );
  kt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
    .clk(clk), .reset(reset), .btn_n_i(btn_min_n), .press_o(press.min)
  );
  kt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sec (
    .clk(clk), .reset(reset), .btn_n_i(btn_sec_n), .press_o(press.sec)
  );
  kt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .btn_n_i(btn_clr_n), .press_o(press.clr)
  );

  assign any_press = press.start | press.min | press.sec | press.clr;
  assign pre_tc    = (pre_q == PRE_W'(PRE_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      asec_q    <= '0;
      sec_bin_q <= 1'b0;
      min_bin_q <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      asec_q    <= asec_d;
      sec_bin_q <= sec_bin_d;
      min_bin_q <= min_bin_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      buzzer_q  <= buzzer_d;
    end
  end

  // Next state, prescaler and pulse requests; pulses land one cycle after the event
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    asec_d    = asec_q;
    sec_bin_d = 1'b0;
    min_bin_d = 1'b0;
    clr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (press.start && !zero) begin
          state_d = RUN;
          pre_d   = '0;
        end else if (press.clr) begin
          clr_d = 1'b1;
        end else begin
          sec_bin_d = press.sec;
          min_bin_d = press.min;
        end
      end
      RUN: begin
        if (zero) begin
          state_d = ALARM;
          pre_d   = '0;
          asec_d  = '0;
        end else begin
          pre_d     = pre_tc ? '0 : pre_q + PRE_W'(1);
          sec_bin_d = pre_tc;
          if (press.start) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (press.start) begin
          state_d = RUN;
        end else if (press.clr) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ALARM: begin
        pre_d = pre_tc ? '0 : pre_q + PRE_W'(1);
        if (any_press) begin
          state_d = IDLE;
        end else if (pre_tc) begin
          if (asec_q == ASEC_W'(ASEC_MAX)) state_d = IDLE;
          else                             asec_d  = asec_q + ASEC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running_d = (state_d == RUN);
  end

`ifdef KTIMER_CHIRP_EN
  localparam int unsigned CHIRP_DIV = (CLK_HZ / 8 > 1) ? CLK_HZ / 8 : 1;
  localparam int unsigned CH_W      = cnt_w(CHIRP_DIV);

  logic [CH_W-1:0] chirp_q, chirp_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) chirp_q <= '0;
    else       chirp_q <= chirp_d;
  end

  // Buzzer starts high on ALARM entry and toggles every CHIRP_DIV cycles
  always_comb begin
    chirp_d  = '0;
    buzzer_d = 1'b0;
    if (state_d == ALARM) begin
      if (state_q != ALARM) begin
        buzzer_d = 1'b1;
      end else if (chirp_q == CH_W'(CHIRP_DIV - 1)) begin
        buzzer_d = ~buzzer_q;
      end else begin
        buzzer_d = buzzer_q;
        chirp_d  = chirp_q + CH_W'(1);
      end
    end
  end
`else
  always_comb begin
    buzzer_d = (state_d == ALARM);
  end
`endif

  assign sec_bin = sec_bin_q;
  assign min_bin = min_bin_q;
  assign clr     = clr_q;
  assign running = running_q;
  assign buzzer  = buzzer_q;

endmodule

// File: tb/tb_ktimer_ctrl.sv
// Directed bench for ktimer_ctrl with CLK_HZ=10, DEBOUNCE_CYCLES=2, ALARM_SECS=3.
module tb_ktimer_ctrl;

  localparam logic [3:0] B_START = 4'b1000;
  localparam logic [3:0] B_MIN   = 4'b0100;
  localparam logic [3:0] B_SEC   = 4'b0010;
  localparam logic [3:0] B_CLR   = 4'b0001;

  logic clk, reset;
  logic btn_start_n, btn_min_n, btn_sec_n, btn_clr_n;
  logic zero;
  logic sec_bin, min_bin, clr, running, buzzer;

  ktimer_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYCLES(2), .ALARM_SECS(3)) dut (
    .clk(clk), .reset(reset),
    .btn_start_n(btn_start_n), .btn_min_n(btn_min_n),
    .btn_sec_n(btn_sec_n), .btn_clr_n(btn_clr_n),
    .zero(zero),
    .sec_bin(sec_bin), .min_bin(min_bin), .clr(clr),
    .running(running), .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       zero;
    logic       exp_sec;
    logic       exp_min;
    logic       exp_clr;
    logic       exp_run;
    string      name;
  } vec_t;

  int   checks, errors;
  int   cyc, run_rise, run_cnt;
  int   sec_cyc[$];
  bit   wide;
  logic prev_sec, prev_run;
  logic p_sec, p_min, p_clr, p_run, p_buz;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and record what the outputs did
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sec_bin) begin
      sec_cyc.push_back(cyc);
      if (prev_sec) wide = 1'b1;
    end
    if (running && !prev_run) run_rise = cyc;
    if (running && !sec_bin) run_cnt++;
    prev_sec = sec_bin;
    prev_run = running;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(input logic [3:0] m);
    btn_start_n = ~m[3];
    btn_min_n   = ~m[2];
    btn_sec_n   = ~m[1];
    btn_clr_n   = ~m[0];
  endtask

  // Hold buttons 5 cycles (event output visible on the 5th), release, let release settle
  task automatic press(input logic [3:0] m);
    set_btn(m);
    idle(5);
    p_sec = sec_bin;
    p_min = min_bin;
    p_clr = clr;
    p_run = running;
    p_buz = buzzer;
    set_btn(4'b0000);
    idle(4);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   t0, t1, rr, buz_bad, exp_buz;
    logic early;

    vecs[0] = '{B_SEC,                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "idle_sec"};
    vecs[1] = '{B_MIN,                 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "idle_min"};
    vecs[2] = '{B_MIN | B_SEC,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "idle_min_sec"};
    vecs[3] = '{B_CLR,                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "idle_clr"};
    vecs[4] = '{B_CLR | B_SEC | B_MIN, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "idle_clr_wins"};
    vecs[5] = '{B_START,               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_start_zero"};
    vecs[6] = '{B_START | B_CLR | B_MIN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "idle_start_wins"};

    checks = 0; errors = 0; cyc = 0; run_rise = -1; run_cnt = 0;
    wide = 1'b0; prev_sec = 1'b0; prev_run = 1'b0;
    reset = 1'b1; zero = 1'b1;
    set_btn(4'b0000);

    idle(3);
    check("rst_sec_bin", int'(sec_bin), 0);
    check("rst_min_bin", int'(min_bin), 0);
    check("rst_clr",     int'(clr), 0);
    check("rst_running", int'(running), 0);
    check("rst_buzzer",  int'(buzzer), 0);
    reset = 1'b0;
    idle(2);

    // IDLE-state vectors: event output 5 cycles after the press, then gone
    for (int i = 0; i < 7; i++) begin
      zero = vecs[i].zero;
      set_btn(vecs[i].btn);
      early = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        tick();
        early |= sec_bin | min_bin | clr | running;
      end
      tick();
      check({vecs[i].name, "_early"},   int'(early), 0);
      check({vecs[i].name, "_sec_bin"}, int'(sec_bin), int'(vecs[i].exp_sec));
      check({vecs[i].name, "_min_bin"}, int'(min_bin), int'(vecs[i].exp_min));
      check({vecs[i].name, "_clr"},     int'(clr), int'(vecs[i].exp_clr));
      check({vecs[i].name, "_running"}, int'(running), int'(vecs[i].exp_run));
      set_btn(4'b0000);
      tick();
      check({vecs[i].name, "_one_cycle"}, int'(sec_bin | min_bin | clr), 0);
      idle(3);
    end

    // Asynchronous reset out of RUN
    #2 reset = 1'b1;
    #1 check("async_reset_running", int'(running), 0);
    idle(2);
    reset = 1'b0;
    tick();
    check("post_reset_running", int'(running), 0);

    // RUN cadence, then zero forces ALARM for 3 seconds
    zero = 1'b0;
    sec_cyc.delete();
    wide = 1'b0;
    run_rise = -1;
    t0 = cyc;
    set_btn(B_START);
    idle(5);
    set_btn(4'b0000);
    check("run_entry_latency", run_rise - t0, 5);
    rr = run_rise;
    while (cyc < rr + 31 && cyc < t0 + 100) tick();
    check("run_sec_count", sec_cyc.size(), 3);
    for (int k = 0; k < 3; k++)
      check("run_sec_time", (k < sec_cyc.size()) ? sec_cyc[k] - rr : -1, 10 * (k + 1));
    check("run_sec_width", int'(wide), 0);
    sec_cyc.delete();
    zero = 1'b1;
    tick();
    check("alarm_entry_buzzer", int'(buzzer), 1);
    check("alarm_entry_running", int'(running), 0);
    buz_bad = 0;
    for (int k = 1; k < 30; k++) begin
      tick();
`ifdef KTIMER_CHIRP_EN
      exp_buz = ((k % 2) == 0) ? 1 : 0;
`else
      exp_buz = 1;
`endif
      if (int'(buzzer) != exp_buz || running) buz_bad++;
    end
    check("alarm_hold", buz_bad, 0);
    tick();
    check("alarm_timeout_buzzer", int'(buzzer), 0);
    check("alarm_no_sec_bin", sec_cyc.size(), 0);

    // Pause 4 cycles into a second, resume, finish the second
    zero = 1'b0;
    sec_cyc.delete();
    run_rise = -1;
    t0 = cyc;
    press(B_START);
    check("pause_run_entry", run_rise - t0, 5);
    run_cnt = 0;
    t1 = cyc;
    set_btn(B_START);
    idle(5);
    set_btn(4'b0000);
    check("pause_entry_running", int'(running), 0);
    idle(20);
    check("pause_frozen_running", int'(running), 0);
    check("pause_frozen_no_sec", sec_cyc.size(), 0);
    run_cnt = run_cnt + 5;
    set_btn(B_START);
    idle(5);
    set_btn(4'b0000);
    check("resume_running", int'(running), 1);
    tick();
    check("resume_sec_bin", int'(sec_bin), 1);
    check("resume_run_cycles", run_cnt, 10);
    idle(3);

    // PAUSE then clear: clr pulse and back to IDLE, where sec presses step the digit
    press(B_START);
    check("pause2_running", int'(running), 0);
    press(B_CLR);
    check("pause_clr_pulse", int'(p_clr), 1);
    check("pause_clr_running", int'(p_run), 0);
    press(B_SEC);
    check("after_clr_idle_sec", int'(p_sec), 1);

    // Bounce rejected, a steady 3-cycle press accepted once
    zero = 1'b1;
    sec_cyc.delete();
    set_btn(B_SEC);
    tick();
    set_btn(4'b0000);
    tick();
    set_btn(B_SEC);
    tick();
    set_btn(4'b0000);
    idle(8);
    check("bounce_reject", sec_cyc.size(), 0);
    set_btn(B_SEC);
    idle(3);
    set_btn(4'b0000);
    idle(8);
    check("hold3_single_event", sec_cyc.size(), 1);

    // zero and start in the same RUN cycle: ALARM wins; any press then ends ALARM
    zero = 1'b0;
    press(B_START);
    check("sim_run_entry", int'(p_run), 1);
    set_btn(B_START);
    idle(4);
    zero = 1'b1;
    tick();
    check("zero_beats_start_buzzer", int'(buzzer), 1);
    check("zero_beats_start_running", int'(running), 0);
    set_btn(4'b0000);
    idle(4);
    press(B_SEC);
    check("alarm_press_exit_buzzer", int'(p_buz), 0);
    check("alarm_press_no_sec_bin", int'(p_sec), 0);
    check("alarm_press_running", int'(p_run), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
